// File: rtl/vcid_demux_stage.sv
// VC-ID demux stage: steers each valid word from the Main FIFO pop stage into
// the VC0 or VC1 FIFO by its select bit. Pushes are registered (1-cycle latency).
// Saturating per-VC push counters, a drop counter and a sticky drop flag track traffic.
module vcid_demux_stage #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned VC_BIT = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] demux_vcid_in,
   input  logic              demux_vcid_valid_in,
   input  logic              VC0_full,
   input  logic              VC1_full,
   input  logic              clr_counts,
   output logic [DATA_W-1:0] VC0_data_in,
   output logic              VC0_push,
   output logic [DATA_W-1:0] VC1_data_in,
   output logic              VC1_push,
   output logic [CNT_W-1:0]  VC0_count,
   output logic [CNT_W-1:0]  VC1_count,
   output logic [CNT_W-1:0]  drop_count,
   output logic              drop_err
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              sel;
   logic              acc0, acc1, drop;
   logic [DATA_W-1:0] vc0_data_d, vc0_data_q, vc1_data_d, vc1_data_q;
   logic              vc0_push_d, vc0_push_q, vc1_push_d, vc1_push_q;
   logic [CNT_W-1:0]  vc0_cnt_d, vc0_cnt_q, vc1_cnt_d, vc1_cnt_q, drop_cnt_d, drop_cnt_q;
   logic              drop_err_d, drop_err_q;

   // Clear wins over the old value, but an event in the clearing cycle still counts as one.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                 input logic ev, input logic clr);
      logic [CNT_W-1:0] res;
      if (clr) begin
         res = ev ? CntOne : '0;
      end else if (ev && (cur != CntMax)) begin
         res = cur + CntOne;
      end else begin
         res = cur;
      end
      return res;
   endfunction

   // Decode target VC and whether its FIFO can take the word this cycle.
   always_comb begin
      sel  = demux_vcid_in[VC_BIT];
      acc0 = demux_vcid_valid_in && !sel && !VC0_full;
      acc1 = demux_vcid_valid_in &&  sel && !VC1_full;
      drop = demux_vcid_valid_in && (sel ? VC1_full : VC0_full);
   end

   // Next-state for push/data outputs, counters and the sticky drop flag.
   always_comb begin
      vc0_push_d = acc0;
      vc1_push_d = acc1;
      vc0_data_d = acc0 ? demux_vcid_in : '0;
      vc1_data_d = acc1 ? demux_vcid_in : '0;
      vc0_cnt_d  = cnt_next(vc0_cnt_q, acc0, clr_counts);
      vc1_cnt_d  = cnt_next(vc1_cnt_q, acc1, clr_counts);
      drop_cnt_d = cnt_next(drop_cnt_q, drop, clr_counts);
      drop_err_d = clr_counts ? drop : (drop_err_q || drop);
   end

   // State registers; reset overrides everything, including a word in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         vc0_data_q <= '0;
         vc1_data_q <= '0;
         vc0_push_q <= 1'b0;
         vc1_push_q <= 1'b0;
         vc0_cnt_q  <= '0;
         vc1_cnt_q  <= '0;
         drop_cnt_q <= '0;
         drop_err_q <= 1'b0;
      end else begin
         vc0_data_q <= vc0_data_d;
         vc1_data_q <= vc1_data_d;
         vc0_push_q <= vc0_push_d;
         vc1_push_q <= vc1_push_d;
         vc0_cnt_q  <= vc0_cnt_d;
         vc1_cnt_q  <= vc1_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign VC0_data_in = vc0_data_q;
   assign VC1_data_in = vc1_data_q;
   assign VC0_push    = vc0_push_q;
   assign VC1_push    = vc1_push_q;
   assign VC0_count   = vc0_cnt_q;
   assign VC1_count   = vc1_cnt_q;
   assign drop_count  = drop_cnt_q;
   assign drop_err    = drop_err_q;

endmodule

// File: tb/tb_vcid_demux_stage.sv
// Directed testbench for vcid_demux_stage with hand-computed expectations.
module tb_vcid_demux_stage;

   logic       clk;
   logic       reset;
   logic [5:0] demux_vcid_in;
   logic       demux_vcid_valid_in;
   logic       VC0_full, VC1_full, clr_counts;
   logic [5:0] VC0_data_in, VC1_data_in;
   logic       VC0_push, VC1_push;
   logic [7:0] VC0_count, VC1_count, drop_count;
   logic       drop_err;

   int errors = 0;
   int checks = 0;

   vcid_demux_stage #(.DATA_W(6), .VC_BIT(4), .CNT_W(8)) dut (
      .clk                 (clk),
      .reset               (reset),
      .demux_vcid_in       (demux_vcid_in),
      .demux_vcid_valid_in (demux_vcid_valid_in),
      .VC0_full            (VC0_full),
      .VC1_full            (VC1_full),
      .clr_counts          (clr_counts),
      .VC0_data_in         (VC0_data_in),
      .VC0_push            (VC0_push),
      .VC1_data_in         (VC1_data_in),
      .VC1_push            (VC1_push),
      .VC0_count           (VC0_count),
      .VC1_count           (VC1_count),
      .drop_count          (drop_count),
      .drop_err            (drop_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] w);
      demux_vcid_valid_in = v;
      demux_vcid_in       = w;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 6'h3F);
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if ({VC0_push, VC0_data_in, VC1_push, VC1_data_in} !== 14'h0) begin
            errors++;
            $display("FAIL reset_push cyc%0d: got %h want 0", i,
                     {VC0_push, VC0_data_in, VC1_push, VC1_data_in});
         end
         checks++;
         if ({VC0_count, VC1_count, drop_count, drop_err} !== 25'h0) begin
            errors++;
            $display("FAIL reset_counts cyc%0d: got %h want 0", i,
                     {VC0_count, VC1_count, drop_count, drop_err});
         end
      end
      reset = 1'b0;
      drive(1'b0, 6'h00);
      step();
   endtask

   task automatic test_routing();
      logic [5:0] words [4];
      logic [13:0] exp;
      words[0] = 6'h05; words[1] = 6'h15; words[2] = 6'h0A; words[3] = 6'h1A;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, words[i]);
         step();
         exp = words[i][4] ? {1'b0, 6'h00, 1'b1, words[i]} : {1'b1, words[i], 1'b0, 6'h00};
         checks++;
         if ({VC0_push, VC0_data_in, VC1_push, VC1_data_in} !== exp) begin
            errors++;
            $display("FAIL route_w%0d: got %h want %h", i,
                     {VC0_push, VC0_data_in, VC1_push, VC1_data_in}, exp);
         end
      end
      drive(1'b0, 6'h2B);
      step();
      checks++;
      if ({VC0_push, VC0_data_in, VC1_push, VC1_data_in} !== 14'h0) begin
         errors++;
         $display("FAIL idle_outputs: got %h want 0",
                  {VC0_push, VC0_data_in, VC1_push, VC1_data_in});
      end
      checks++;
      if ({VC0_count, VC1_count} !== {8'd2, 8'd2}) begin
         errors++;
         $display("FAIL route_counts: got %0d/%0d want 2/2", VC0_count, VC1_count);
      end
   endtask

   task automatic test_full_drop();
      VC1_full = 1'b1;
      drive(1'b1, 6'h12);
      step();
      checks++;
      if ({VC0_push, VC1_push, drop_count, drop_err} !== {1'b0, 1'b0, 8'd1, 1'b1}) begin
         errors++;
         $display("FAIL drop_vc1: got push=%b%b drop=%0d err=%b want 00 1 1",
                  VC0_push, VC1_push, drop_count, drop_err);
      end
      drive(1'b1, 6'h02);
      step();
      checks++;
      if ({VC0_push, VC0_data_in, VC1_push} !== {1'b1, 6'h02, 1'b0}) begin
         errors++;
         $display("FAIL after_drop_vc0: got push=%b data=%h vc1push=%b want 1 02 0",
                  VC0_push, VC0_data_in, VC1_push);
      end
      checks++;
      if ({VC0_count, drop_count} !== {8'd3, 8'd1}) begin
         errors++;
         $display("FAIL after_drop_counts: got %0d/%0d want 3/1", VC0_count, drop_count);
      end
      VC1_full = 1'b0;
      drive(1'b0, 6'h00);
      step();
   endtask

   task automatic test_saturate_clear();
      clr_counts = 1'b1;
      step();
      clr_counts = 1'b0;
      checks++;
      if ({VC0_count, VC1_count, drop_count, drop_err} !== 25'h0) begin
         errors++;
         $display("FAIL clr_idle: got %h want 0", {VC0_count, VC1_count, drop_count, drop_err});
      end
      // Re-arm drop_err so the later clear has something to clear.
      VC0_full = 1'b1;
      drive(1'b1, 6'h01);
      step();
      VC0_full = 1'b0;
      checks++;
      if ({drop_count, drop_err, VC0_push} !== {8'd1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL drop_vc0: got drop=%0d err=%b push=%b want 1 1 0",
                  drop_count, drop_err, VC0_push);
      end
      for (int i = 0; i < 260; i++) begin
         drive(1'b1, 6'h01);
         step();
         if (i == 99 || i == 253 || i == 254) begin
            checks++;
            if (VC0_count !== 8'(i + 1)) begin
               errors++;
               $display("FAIL sat_ramp_%0d: got %0d want %0d", i, VC0_count, i + 1);
            end
         end
      end
      checks++;
      if ({VC0_count, VC1_count, VC0_push, VC0_data_in} !== {8'd255, 8'd0, 1'b1, 6'h01}) begin
         errors++;
         $display("FAIL sat_hold: got vc0=%0d vc1=%0d push=%b data=%h want 255 0 1 01",
                  VC0_count, VC1_count, VC0_push, VC0_data_in);
      end
      clr_counts = 1'b1;
      drive(1'b1, 6'h07);
      step();
      checks++;
      if ({VC0_count, VC1_count, drop_count, drop_err} !== {8'd1, 8'd0, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL clr_with_event: got vc0=%0d vc1=%0d drop=%0d err=%b want 1 0 0 0",
                  VC0_count, VC1_count, drop_count, drop_err);
      end
      checks++;
      if ({VC0_push, VC0_data_in} !== {1'b1, 6'h07}) begin
         errors++;
         $display("FAIL clr_push: got push=%b data=%h want 1 07", VC0_push, VC0_data_in);
      end
      // Clear coinciding with a drop keeps drop_err set.
      VC0_full = 1'b1;
      drive(1'b1, 6'h03);
      step();
      checks++;
      if ({VC0_count, drop_count, drop_err} !== {8'd0, 8'd1, 1'b1}) begin
         errors++;
         $display("FAIL clr_with_drop: got vc0=%0d drop=%0d err=%b want 0 1 1",
                  VC0_count, drop_count, drop_err);
      end
      clr_counts = 1'b0;
      VC0_full   = 1'b0;
      drive(1'b0, 6'h00);
      step();
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 6'h10);
      step();
      checks++;
      if ({VC1_push, VC1_data_in, VC0_push} !== {1'b1, 6'h10, 1'b0}) begin
         errors++;
         $display("FAIL pre_reset_push: got push=%b data=%h vc0push=%b want 1 10 0",
                  VC1_push, VC1_data_in, VC0_push);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({VC0_push, VC0_data_in, VC1_push, VC1_data_in, VC0_count, VC1_count, drop_count,
           drop_err} !== 39'h0) begin
         errors++;
         $display("FAIL midstream_reset: got %h want 0", {VC0_push, VC0_data_in, VC1_push,
                  VC1_data_in, VC0_count, VC1_count, drop_count, drop_err});
      end
      reset = 1'b0;
      drive(1'b0, 6'h00);
      step();
   endtask

   task automatic test_other_full();
      VC0_full = 1'b1;
      VC1_full = 1'b0;
      drive(1'b1, 6'h11);
      step();
      checks++;
      if ({VC1_push, VC1_data_in, VC0_push} !== {1'b1, 6'h11, 1'b0}) begin
         errors++;
         $display("FAIL other_full_push: got push=%b data=%h vc0push=%b want 1 11 0",
                  VC1_push, VC1_data_in, VC0_push);
      end
      checks++;
      if ({drop_count, drop_err, VC1_count} !== {8'd0, 1'b0, 8'd1}) begin
         errors++;
         $display("FAIL other_full_counts: got drop=%0d err=%b vc1=%0d want 0 0 1",
                  drop_count, drop_err, VC1_count);
      end
      VC0_full = 1'b0;
      drive(1'b0, 6'h00);
      step();
   endtask

   initial begin
      reset      = 1'b1;
      VC0_full   = 1'b0;
      VC1_full   = 1'b0;
      clr_counts = 1'b0;
      drive(1'b1, 6'h3F);
      test_reset();
      test_routing();
      test_full_drop();
      test_saturate_clear();
      test_reset_midstream();
      test_other_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vcid_demux_stage.md
Name: vcid_demux_stage

Overview:
Sits directly downstream of the Main FIFO pop-condition stage. It takes each valid 6-bit word on demux_vcid_in/demux_vcid_valid_in and steers it into the VC0 or VC1 FIFO according to a VC-select bit in the word. Push outputs are registered with one cycle of latency. Per-VC routed-word counters and a drop counter support the fill and QoS verification benches.

Parameters:
DATA_W, 6, word width; must match the Main FIFO data width
VC_BIT, 4, index of the bit in the word that selects the VC (0 = VC0, 1 = VC1)
CNT_W, 8, width of each statistics counter

Ports:
clk  input  1  single clock; all logic is on its rising edge
reset  input  1  synchronous, active-high
demux_vcid_in  input  DATA_W  word from the pop-condition stage
demux_vcid_valid_in  input  1  qualifies demux_vcid_in for one cycle
VC0_full  input  1  full flag from the VC0 FIFO
VC1_full  input  1  full flag from the VC1 FIFO
clr_counts  input  1  synchronous clear of all counters
VC0_data_in  output  DATA_W  write data to the VC0 FIFO
VC0_push  output  1  write strobe to the VC0 FIFO
VC1_data_in  output  DATA_W  write data to the VC1 FIFO
VC1_push  output  1  write strobe to the VC1 FIFO
VC0_count  output  CNT_W  words pushed to VC0, saturating
VC1_count  output  CNT_W  words pushed to VC1, saturating
drop_count  output  CNT_W  words dropped because the target FIFO was full, saturating
drop_err  output  1  sticky flag, set on the first drop

Behaviour:
- Reset, sampled on the clk edge while reset=1:
  - all outputs go to 0: data, push, counts, drop_err.
  - reset takes priority over every other input.
  - a word presented in the same cycle as reset is discarded and not counted.
- Routing:
  - sel = demux_vcid_in[VC_BIT].
  - When valid_in=1 and sel=0 and VC0_full=0: on the next edge VC0_data_in <= word, VC0_push <= 1, VC0_count increments.
  - When valid_in=1 and sel=1 and VC1_full=0: same behaviour on the VC1 outputs.
- Latency: exactly 1 cycle from valid_in to push. The full data word, including the select bit, is forwarded unmodified.
- Idle:
  - When valid_in=0: both pushes <= 0 and both data outputs <= 0.
  - The non-selected VC always gets push=0 and data=0.
  - At most one push is high in any cycle.
- Full handling:
  - The full flag of the target VC is sampled in the same cycle as valid_in.
  - If the target VC is full: no push, drop_count increments, drop_err <= 1.
  - The other VC's full flag has no effect on the word.
  - No buffering or retry is performed. The upstream stage is responsible for throttling on the almost-full flags, so any drop indicates a protocol violation.
- Counters:
  - All counters saturate at 2^CNT_W-1 and never wrap.
  - clr_counts=1 with no event that cycle: the counter becomes 0.
  - clr_counts=1 with an event that cycle: the affected counter becomes 1.
  - clr_counts also clears drop_err, except that a drop in the same cycle leaves drop_err=1.
  - clr_counts does not affect the routing or push outputs.
- Back-to-back traffic:
  - Accepts one word per cycle indefinitely.
  - Consecutive words to alternating VCs produce alternating single-cycle pushes with no bubbles.
- Reset mid-stream: a push registered in the cycle before reset still appears for that one cycle. From the first reset edge onward all outputs are 0.
- Unknown inputs: a valid_in of X is not a legal input. The bench must drive valid_in to 0 or 1 at all times after reset.

Test Plan:
- Hold reset=1 for 2 cycles with valid_in=1 and word 6'h3F → all outputs stay 0, counts=0, drop_err=0.
- Send words 6'h05, 6'h15, 6'h0A, 6'h1A on consecutive cycles, no full flags → one cycle later VC0 pushes 05, then VC1 pushes 15, then VC0 0A, then VC1 1A. Final counts: VC0_count=2, VC1_count=2.
- Set VC1_full=1 and send 6'h12 → no push on either VC, drop_count=1, drop_err=1. Then send 6'h02 → VC0 pushes 02 one cycle later.
- Send 260 VC0 words back-to-back → VC0_count saturates at 255 and VC1_count stays 0. Then assert clr_counts together with a VC0 word → VC0_count=1, drop_err=0.
- Send 6'h10 one cycle before reset is asserted → VC1_push=1 with data 10 for exactly one cycle, then everything reads 0 from the first reset edge.
- Set VC0_full=1 and VC1_full=0, then send 6'h11 → VC1 pushes 11 and drop_count stays unchanged.
